// File: rtl/pocket_tracker.sv
// Debounces per-frame ball-in-hole strobes, latches pocketed balls, keeps score and runs the cue-ball respawn FSM.
// Latency: flags/score/pulses update on the edge sampling startOfFrame, visible next cycle; no backpressure.
module pocket_tracker #(
    parameter int CONFIRM_FRAMES  = 2,
    parameter int RESPAWN_FRAMES  = 60,
    parameter int SCRATCH_PENALTY = 1,
    parameter int SCORE_W         = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               new_game,
    input  logic               ballA_scored,
    input  logic               ballB_scored,
    input  logic               ballC_scored,
    input  logic               ballD_scored,
    output logic [3:0]         ball_pocketed,
    output logic               pocket_event,
    output logic [3:0]         pocket_mask,
    output logic               cue_respawn,
    output logic [SCORE_W-1:0] score,
    output logic               table_cleared
);
    localparam int CW        = $clog2(CONFIRM_FRAMES + 1);
    localparam int TW        = $clog2(RESPAWN_FRAMES + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {ON_TABLE, IN_POCKET, RESPAWN} cue_state_t;

    cue_state_t        state_q;
    logic [TW-1:0]     timer_q;
    logic [3:0]        seen_q, seen_d;
    logic [CW-1:0]     cnt_q [4];
    logic [CW-1:0]     cnt_d [4];
    logic [3:0]        pocketed_q, pocketed_d;
    logic [3:0]        new_mask;
    logic              event_q;
    logic [3:0]        mask_q;
    logic              respawn_q;
    logic              respawn_go;
    logic [SCORE_W-1:0] score_q, score_d;
    logic              cleared_q;
    logic [3:0]        scored;
    int                score_sum;

    assign scored     = {ballD_scored, ballC_scored, ballB_scored, ballA_scored};
    assign respawn_go = (state_q == IN_POCKET) && startOfFrame && (timer_q == TW'(1));

    always_comb begin
        seen_d    = seen_q | (scored & ~pocketed_q);
        new_mask  = '0;
        score_sum = 0;
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        if (startOfFrame) begin
            // Strobes on the frame-boundary cycle belong to the new frame.
            seen_d = scored & ~pocketed_q;
            for (int i = 0; i < 4; i++) begin
                if (!pocketed_q[i]) begin
                    if (seen_q[i]) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                        if (cnt_q[i] == CW'(CONFIRM_FRAMES - 1)) new_mask[i] = 1'b1;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
            end
        end
        if (state_q == RESPAWN) begin
            seen_d[0] = 1'b0;
            cnt_d[0]  = '0;
        end
        pocketed_d = pocketed_q | new_mask;
        if (respawn_go) pocketed_d[0] = 1'b0;

        score_sum = int'(score_q) + int'(new_mask[1]) + int'(new_mask[2]) + int'(new_mask[3])
                    - (new_mask[0] ? SCRATCH_PENALTY : 0);
        if (score_sum < 0)              score_d = '0;
        else if (score_sum > SCORE_MAX) score_d = SCORE_W'(SCORE_MAX);
        else                            score_d = SCORE_W'(score_sum);
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN || new_game) begin
            state_q    <= ON_TABLE;
            timer_q    <= '0;
            seen_q     <= '0;
            pocketed_q <= '0;
            event_q    <= 1'b0;
            mask_q     <= '0;
            respawn_q  <= 1'b0;
            score_q    <= '0;
            cleared_q  <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            seen_q     <= seen_d;
            pocketed_q <= pocketed_d;
            event_q    <= |new_mask;
            mask_q     <= new_mask;
            respawn_q  <= respawn_go;
            score_q    <= score_d;
            cleared_q  <= &pocketed_d[3:1];
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            case (state_q)
                ON_TABLE: if (new_mask[0]) begin
                    state_q <= IN_POCKET;
                    timer_q <= TW'(RESPAWN_FRAMES);
                end
                IN_POCKET: if (startOfFrame) begin
                    timer_q <= timer_q - TW'(1);
                    if (timer_q == TW'(1)) state_q <= RESPAWN;
                end
                default: state_q <= ON_TABLE;
            endcase
        end
    end

    assign ball_pocketed = pocketed_q;
    assign pocket_event  = event_q;
    assign pocket_mask   = mask_q;
    assign cue_respawn   = respawn_q;
    assign score         = score_q;
    assign table_cleared = cleared_q;
endmodule

// File: tb/tb_pocket_tracker.sv
// Randomised frame-level stimulus for pocket_tracker checked against a per-frame reference model.
module tb_pocket_tracker;
    localparam int CONF = 2;
    localparam int RESP = 60;
    localparam int PEN  = 1;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          resetN = 1'b1;
    logic          sof = 1'b0, ng = 1'b0;
    logic          a_s = 1'b0, b_s = 1'b0, c_s = 1'b0, d_s = 1'b0;
    logic [3:0]    pocketed, mask;
    logic          evt, respawn, cleared;
    logic [SW-1:0] score;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, advanced once per frame boundary.
    bit [3:0] m_pk;
    int       m_cnt [4];
    int       m_score;
    bit       m_inpk;
    int       m_timer;
    bit [3:0] m_acc;
    bit [3:0] m_mask;
    bit       m_resp;

    pocket_tracker #(
        .CONFIRM_FRAMES(CONF), .RESPAWN_FRAMES(RESP),
        .SCRATCH_PENALTY(PEN), .SCORE_W(SW)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .new_game(ng),
        .ballA_scored(a_s), .ballB_scored(b_s), .ballC_scored(c_s), .ballD_scored(d_s),
        .ball_pocketed(pocketed), .pocket_event(evt), .pocket_mask(mask),
        .cue_respawn(respawn), .score(score), .table_cleared(cleared)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pk = '0; m_score = 0; m_inpk = 0; m_timer = 0;
        m_acc = '0; m_mask = '0; m_resp = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_frame_edge();
        m_mask = '0;
        m_resp = 0;
        for (int x = 1; x < 4; x++) begin
            if (!m_pk[x]) begin
                m_cnt[x] = m_acc[x] ? m_cnt[x] + 1 : 0;
                if (m_cnt[x] == CONF) begin m_pk[x] = 1; m_mask[x] = 1; end
            end
        end
        if (m_inpk) begin
            m_timer--;
            if (m_timer == 0) begin
                m_inpk = 0; m_pk[0] = 0; m_cnt[0] = 0; m_resp = 1;
            end
        end else begin
            m_cnt[0] = m_acc[0] ? m_cnt[0] + 1 : 0;
            if (m_cnt[0] == CONF) begin
                m_pk[0] = 1; m_mask[0] = 1; m_inpk = 1; m_timer = RESP;
            end
        end
        m_score = m_score + $countones(m_mask[3:1]) - (m_mask[0] ? PEN : 0);
        if (m_score < 0) m_score = 0;
        if (m_score > SMAX) m_score = SMAX;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pocketed"}, 32'(pocketed), 32'(m_pk));
        check({tag, ".event"},    32'(evt),      32'(m_mask != 0));
        check({tag, ".mask"},     32'(mask),     32'(m_mask));
        check({tag, ".respawn"},  32'(respawn),  32'(m_resp));
        check({tag, ".score"},    32'(score),    32'(m_score));
        check({tag, ".cleared"},  32'(cleared),  32'(m_pk[3:1] == 3'b111));
    endtask

    // One video frame: sof on position 0, strobes for balls in act spread over the frame.
    task automatic run_frame(input bit do_ng, input bit [3:0] act);
        int L, lo, p;
        bit [3:0] st [6];
        L = $urandom_range(3, 6);
        for (int i = 0; i < 6; i++) st[i] = '0;
        for (int x = 0; x < 4; x++) begin
            if (act[x]) begin
                lo = (x == 0) ? 2 : (do_ng ? 1 : 0);
                p  = $urandom_range(lo, L - 1);
                for (int pos = lo; pos < L; pos++)
                    st[pos][x] = (pos == p) || ($urandom % 2 == 0);
            end
        end
        for (int pos = 0; pos < L; pos++) begin
            sof = (pos == 0);
            ng  = (pos == 0) && do_ng;
            {d_s, c_s, b_s, a_s} = st[pos];
            @(posedge clk);
            #1;
            if (pos == 0) begin
                if (do_ng) model_reset(); else model_frame_edge();
                m_acc = act;
                check_outputs("sof");
            end else if (pos == 1) begin
                check("pulse.event",   32'(evt),     32'(0));
                check("pulse.mask",    32'(mask),    32'(0));
                check("pulse.respawn", 32'(respawn), 32'(0));
            end
        end
        sof = 1'b0; ng = 1'b0;
        {d_s, c_s, b_s, a_s} = 4'b0000;
    endtask

    bit any_resp;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.pocketed", 32'(pocketed), 32'(0));
        check("rst.event",    32'(evt),      32'(0));
        check("rst.score",    32'(score),    32'(0));
        check("rst.respawn",  32'(respawn),  32'(0));
        check("rst.cleared",  32'(cleared),  32'(0));
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // B over two frames -> pocketed, score 1.
        run_frame(0, 4'b0010); run_frame(0, 4'b0010); run_frame(0, 4'b0000);
        check("dirB.score",    32'(score),    32'(1));
        check("dirB.pocketed", 32'(pocketed), 32'(4'b0010));
        // C with a gap frame must not pocket.
        run_frame(0, 4'b0100); run_frame(0, 4'b0000); run_frame(0, 4'b0100);
        check("dirC.gap", 32'(pocketed), 32'(4'b0010));
        run_frame(0, 4'b0100); run_frame(0, 4'b0000);
        check("dirC.pocketed", 32'(pocketed), 32'(4'b0110));
        // D plus ignored B, then table cleared; new_game clears all.
        run_frame(0, 4'b1010); run_frame(0, 4'b1010); run_frame(0, 4'b0000);
        check("dirD.cleared", 32'(cleared), 32'(1));
        check("dirD.score",   32'(score),   32'(3));
        run_frame(1, 4'b0000);
        check("ng.score",    32'(score),    32'(0));
        check("ng.pocketed", 32'(pocketed), 32'(0));
        // Scratch at score 0 saturates.
        run_frame(0, 4'b0001); run_frame(0, 4'b0001); run_frame(0, 4'b0001);
        check("scratch.score",    32'(score),    32'(0));
        check("scratch.pocketed", 32'(pocketed), 32'(4'b0001));

        for (int f = 0; f < 300; f++)
            run_frame(($urandom % 50) == 0,
                      {($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0});

        // Async reset while the cue ball is in the pocket.
        run_frame(1, 4'b0001); run_frame(0, 4'b0001); run_frame(0, 4'b0000);
        check("arst.pre", 32'(pocketed[0]), 32'(1));
        run_frame(0, 4'b0000);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check("arst.pocketed", 32'(pocketed), 32'(0));
        check("arst.score",    32'(score),    32'(0));
        check("arst.event",    32'(evt),      32'(0));
        @(posedge clk);
        #1;
        resetN = 1'b0;
        model_reset();
        any_resp = 0;
        for (int f = 0; f < RESP + 5; f++) begin
            run_frame(0, 4'b0000);
            any_resp |= respawn;
        end
        check("arst.no_respawn", 32'(any_resp), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
